// File: rtl/nios_cpu_debug_ocimem_ctrl_pkg.sv
// Shared definitions for the OCI debug-memory controller.
// Holds the FSM state encoding, jdo field positions and the read-timeout marker word.
// No ports; imported by the controller and its memory-bus interface.
package nios_cpu_debug_ocimem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } state_t;

  localparam int JDO_W         = 38;
  localparam int DATA_W        = 32;
  localparam int JDO_ADDR_LSB  = 18;  // address occupies jdo[ADDR_W+17:18]
  localparam int JDO_RD_FLAG   = 17;
  localparam int JDO_WDATA_LSB = 3;   // write data occupies jdo[34:3]

  // Returned in MonDReg when a read never produces readdatavalid.
  localparam logic [DATA_W-1:0] MON_ERR_DATA = 32'hDEADDEAD;

endpackage

// File: rtl/nios_cpu_debug_ocimem_ctrl_if.sv
// Debug-memory bus bundle between the OCI memory controller and the debug RAM/ROM.
// master: controller side (drives address/read/write/writedata); slave: memory side.
// Reads are split: waitrequest stalls the request, readdatavalid returns data later.
interface nios_cpu_debug_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  import nios_cpu_debug_ocimem_ctrl_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/nios_cpu_debug_ocimem_ctrl.sv
// Executes debug-slave memory commands (load address / read / read-next / write) on the debug RAM port.
// Latency: read pulse to MonDReg update is 3 cycles with no wait states and 1-cycle memory latency.
// Backpressure: mem_waitrequest holds mem_read/mem_write; commands arriving while busy are dropped (mon_overrun).
// Ports: clk/reset_n; jdo + three command pulses from the debug slave; mem_* debug memory port;
//        MonDReg result word; mon_busy/mon_error/mon_overrun status.
module nios_cpu_debug_ocimem_ctrl
  import nios_cpu_debug_ocimem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int RD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [DATA_W-1:0] MonDReg,
  output logic              mon_busy,
  output logic              mon_error,
  output logic              mon_overrun
);

  // Counter only needs to reach RD_TIMEOUT-1.
  localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] mon_a_reg, mon_a_reg_nxt;
  logic [DATA_W-1:0] mon_d_reg_nxt, wdata_nxt;
  logic [CNT_W-1:0]  rd_cnt, rd_cnt_nxt;
  logic              error_nxt, overrun_nxt;
  logic              any_cmd;

  // Only some jdo bits carry fields; fold the rest so the port is visibly consumed.
  logic unused_jdo;
  assign unused_jdo = ^jdo;

  assign any_cmd     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign mem_address = mon_a_reg;
  assign mon_busy    = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    mon_a_reg_nxt = mon_a_reg;
    mon_d_reg_nxt = MonDReg;
    wdata_nxt     = mem_writedata;
    rd_cnt_nxt    = rd_cnt;
    error_nxt     = mon_error;
    overrun_nxt   = mon_overrun;

    case (state)
      IDLE: begin
        // Fixed priority a > b > no_action; losing pulses are silently ignored.
        if (take_action_ocimem_a) begin
          mon_a_reg_nxt = jdo[JDO_ADDR_LSB +: ADDR_W];
          if (jdo[JDO_RD_FLAG]) state_nxt = RD_REQ;
        end else if (take_action_ocimem_b) begin
          wdata_nxt = jdo[JDO_WDATA_LSB +: DATA_W];
          state_nxt = WR_REQ;
        end else if (take_no_action_ocimem_a) begin
          state_nxt = RD_REQ;
        end
      end
      RD_REQ: begin
        if (!mem_waitrequest) begin
          state_nxt  = RD_WAIT;
          rd_cnt_nxt = '0;
        end
      end
      RD_WAIT: begin
        // Data arriving on the final timeout cycle still wins over the timeout.
        if (mem_readdatavalid) begin
          mon_d_reg_nxt = mem_readdata;
          mon_a_reg_nxt = mon_a_reg + ADDR_W'(1);
          state_nxt     = IDLE;
        end else if (rd_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
          mon_d_reg_nxt = MON_ERR_DATA;
          error_nxt     = 1'b1;
          state_nxt     = IDLE;
        end else begin
          rd_cnt_nxt = rd_cnt + CNT_W'(1);
        end
      end
      WR_REQ: begin
        if (!mem_waitrequest) begin
          mon_a_reg_nxt = mon_a_reg + ADDR_W'(1);
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if ((state != IDLE) && any_cmd) overrun_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      mem_writedata <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      rd_cnt        <= '0;
      mon_error     <= 1'b0;
      mon_overrun   <= 1'b0;
    end else begin
      state         <= state_nxt;
      mon_a_reg     <= mon_a_reg_nxt;
      MonDReg       <= mon_d_reg_nxt;
      mem_writedata <= wdata_nxt;
      // Strobes are registered copies of the next state, so they are mutually exclusive.
      mem_read      <= (state_nxt == RD_REQ);
      mem_write     <= (state_nxt == WR_REQ);
      rd_cnt        <= rd_cnt_nxt;
      mon_error     <= error_nxt;
      mon_overrun   <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_nios_cpu_debug_ocimem_ctrl.sv
// Directed bench for the OCI debug-memory controller with a scoreboard of expected completions
// and a small memory model that applies configurable wait states and read latency.
module tb_nios_cpu_debug_ocimem_ctrl;
  import nios_cpu_debug_ocimem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        ta_a = 1'b0, tna_a = 1'b0, ta_b = 1'b0;
  logic [31:0] mon_d_reg;
  logic        mon_busy, mon_error, mon_overrun;

  nios_cpu_debug_ocimem_ctrl_if #(.ADDR_W(8)) bus ();

  nios_cpu_debug_ocimem_ctrl #(.ADDR_W(8), .RD_TIMEOUT(255)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_no_action_ocimem_a (tna_a),
    .take_action_ocimem_b    (ta_b),
    .mem_address             (bus.address),
    .mem_read                (bus.read),
    .mem_write               (bus.write),
    .mem_writedata           (bus.writedata),
    .mem_waitrequest         (bus.waitrequest),
    .mem_readdata            (bus.readdata),
    .mem_readdatavalid       (bus.readdatavalid),
    .MonDReg                 (mon_d_reg),
    .mon_busy                (mon_busy),
    .mon_error               (mon_error),
    .mon_overrun             (mon_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] d;
    logic [7:0]  a;
    int          busy;  // expected busy cycles, -1 = don't care
  } exp_t;
  exp_t sb_q[$];

  // Memory model configuration and observations.
  int          cfg_ws = 0, cfg_lat = 2;
  bit          cfg_never = 1'b0;
  logic [31:0] cfg_data = '0;
  int          ws_left = 0, rd_pend = 0, wr_hold = 0;
  bit          req_prev = 1'b0, wr_stable = 1'b1, both_hi = 1'b0;
  logic [7:0]  first_a = '0, rd_addr = '0, wr_addr = '0;
  logic [31:0] first_d = '0, wr_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
    logic [37:0] j;
    j = '0;
    j[JDO_ADDR_LSB +: 8] = addr;
    j[JDO_RD_FLAG] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_w(input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    j[JDO_WDATA_LSB +: 32] = data;
    return j;
  endfunction

  task automatic pulse(input logic [37:0] j, input logic a, input logic na, input logic b);
    jdo = j; ta_a = a; tna_a = na; ta_b = b;
    tick;
    ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0;
  endtask

  // Wait (bounded) for the controller to return to IDLE, then score the oldest expectation.
  task automatic complete;
    int   n;
    exp_t e;
    n = 0;
    while (mon_busy && n < 1000) begin
      n++;
      tick;
    end
    e = sb_q.pop_front();
    check({e.tag, "_idle"}, {31'd0, mon_busy}, 32'd0);
    if (e.busy >= 0) check({e.tag, "_busy_cycles"}, n, e.busy);
    check({e.tag, "_mondreg"}, mon_d_reg, e.d);
    check({e.tag, "_monareg"}, {24'd0, bus.address}, {24'd0, e.a});
  endtask

  // Memory side: inputs change 1 time unit after each rising edge.
  initial begin
    bus.waitrequest = 1'b0;
    bus.readdata = '0;
    bus.readdatavalid = 1'b0;
    forever begin
      tick;
      bus.readdatavalid = 1'b0;
      if (rd_pend > 0) begin
        rd_pend--;
        if (rd_pend == 0 && !cfg_never) begin
          bus.readdatavalid = 1'b1;
          bus.readdata = cfg_data;
        end
      end
      if (bus.read && bus.write) both_hi = 1'b1;
      if (bus.read || bus.write) begin
        if (!req_prev) begin
          ws_left = cfg_ws; wr_hold = 0; wr_stable = 1'b1;
          first_a = bus.address; first_d = bus.writedata;
        end
        if (bus.address !== first_a || (bus.write && bus.writedata !== first_d)) wr_stable = 1'b0;
        if (bus.write) wr_hold++;
        if (ws_left > 0) begin
          bus.waitrequest = 1'b1;
          ws_left--;
          req_prev = 1'b1;
        end else begin
          bus.waitrequest = 1'b0;
          req_prev = 1'b0;
          if (bus.read) begin
            rd_pend = cfg_lat;
            rd_addr = bus.address;
          end else begin
            wr_addr = bus.address;
            wr_data = bus.writedata;
          end
        end
      end else begin
        bus.waitrequest = 1'b0;
        req_prev = 1'b0;
      end
    end
  end

  initial begin
    // Reset state
    tick; tick;
    check("rst_mondreg", mon_d_reg, 32'd0);
    check("rst_addr", {24'd0, bus.address}, 32'd0);
    check("rst_read", {31'd0, bus.read}, 32'd0);
    check("rst_write", {31'd0, bus.write}, 32'd0);
    check("rst_wdata", bus.writedata, 32'd0);
    check("rst_busy", {31'd0, mon_busy}, 32'd0);
    check("rst_flags", {30'd0, mon_error, mon_overrun}, 32'd0);
    reset_n = 1'b1;
    tick;

    // Load address 0x10 with read; zero wait, data one cycle after acceptance.
    cfg_ws = 0; cfg_lat = 2; cfg_data = 32'h12345678;
    sb_q.push_back('{"rd10", 32'h12345678, 8'h11, 3});
    pulse(jdo_a(8'h10, 1'b1), 1'b1, 1'b0, 1'b0);
    check("rd10_mem_read", {31'd0, bus.read}, 32'd1);
    check("rd10_mem_addr", {24'd0, bus.address}, 32'h10);
    complete;
    check("rd10_acc_addr", {24'd0, rd_addr}, 32'h10);

    // Address-only load then write 0xCAFEF00D with 4 wait states.
    pulse(jdo_a(8'h20, 1'b0), 1'b1, 1'b0, 1'b0);
    check("ld20_idle", {31'd0, mon_busy}, 32'd0);
    check("ld20_addr", {24'd0, bus.address}, 32'h20);
    cfg_ws = 4;
    sb_q.push_back('{"wr20", 32'h12345678, 8'h21, 5});
    pulse(jdo_w(32'hCAFEF00D), 1'b0, 1'b0, 1'b1);
    complete;
    check("wr20_hold", wr_hold, 5);
    check("wr20_stable", {31'd0, wr_stable}, 32'd1);
    check("wr20_addr", {24'd0, wr_addr}, 32'h20);
    check("wr20_data", wr_data, 32'hCAFEF00D);

    // Read at 0xFF wraps the address; read-next then uses address 0.
    cfg_ws = 1; cfg_data = 32'hA5A50001;
    sb_q.push_back('{"rdff", 32'hA5A50001, 8'h00, 4});
    pulse(jdo_a(8'hFF, 1'b1), 1'b1, 1'b0, 1'b0);
    complete;
    check("rdff_acc_addr", {24'd0, rd_addr}, 32'hFF);
    cfg_ws = 0; cfg_data = 32'h0BADF00D;
    sb_q.push_back('{"rdnext", 32'h0BADF00D, 8'h01, 3});
    pulse(jdo_a(8'h77, 1'b0), 1'b0, 1'b1, 1'b0);
    complete;
    check("rdnext_acc_addr", {24'd0, rd_addr}, 32'h00);

    // Simultaneous pulses in IDLE: a wins, then b beats no_action.
    pulse(jdo_a(8'h40, 1'b0), 1'b1, 1'b1, 1'b1);
    check("prio_a_idle", {31'd0, mon_busy}, 32'd0);
    check("prio_a_addr", {24'd0, bus.address}, 32'h40);
    sb_q.push_back('{"prio_b", 32'h0BADF00D, 8'h41, 1});
    pulse(jdo_w(32'h11112222), 1'b0, 1'b1, 1'b1);
    check("prio_b_write", {31'd0, bus.write}, 32'd1);
    complete;
    check("prio_b_data", wr_data, 32'h11112222);
    check("prio_no_overrun", {31'd0, mon_overrun}, 32'd0);

    // Read-next pulse dropped during RD_WAIT.
    cfg_lat = 6; cfg_data = 32'h600DCAFE;
    sb_q.push_back('{"ovr", 32'h600DCAFE, 8'h51, -1});
    pulse(jdo_a(8'h50, 1'b1), 1'b1, 1'b0, 1'b0);
    tick;
    pulse(jdo_a(8'h00, 1'b0), 1'b0, 1'b1, 1'b0);
    check("ovr_flag", {31'd0, mon_overrun}, 32'd1);
    complete;
    tick; tick; tick;
    check("ovr_dropped", {30'd0, mon_busy, bus.read}, 32'd0);

    // Read that never returns data times out after 255 wait cycles.
    check("pre_to_error", {31'd0, mon_error}, 32'd0);
    cfg_never = 1'b1;
    sb_q.push_back('{"tmo", MON_ERR_DATA, 8'h60, 256});
    pulse(jdo_a(8'h60, 1'b1), 1'b1, 1'b0, 1'b0);
    complete;
    check("tmo_error", {31'd0, mon_error}, 32'd1);
    check("tmo_overrun_sticky", {31'd0, mon_overrun}, 32'd1);

    // Reset in RD_WAIT; the late readdatavalid must be ignored.
    cfg_never = 1'b0; cfg_lat = 5; cfg_data = 32'hBAADBEEF;
    pulse(jdo_a(8'h70, 1'b1), 1'b1, 1'b0, 1'b0);
    tick;
    check("rstmid_busy_before", {31'd0, mon_busy}, 32'd1);
    reset_n = 1'b0;
    #2;
    check("rstmid_abort", {31'd0, mon_busy}, 32'd0);
    tick;
    reset_n = 1'b1;
    repeat (6) tick;
    check("rstmid_mondreg", mon_d_reg, 32'd0);
    check("rstmid_state", {30'd0, mon_busy, bus.read}, 32'd0);
    check("rstmid_addr", {24'd0, bus.address}, 32'd0);
    check("rstmid_flags", {30'd0, mon_error, mon_overrun}, 32'd0);

    check("never_both_strobes", {31'd0, both_hi}, 32'd0);
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
